// File: rtl/gate_checker_pkg.sv
// ============================================================================
//  Module      : gate_chk_pkg
//  Description : Shared types and constants for the gate_checker block:
//                FSM state encoding, mismatch-vector bit positions and the
//                width of the result counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gate_chk_pkg;

  // Width of error / sample / capture counters
  localparam int CNT_W = 8;

  // Width of the per-sample mismatch vector
  localparam int VEC_W = 5;

  // Bit positions inside the mismatch vector and gate vectors
  localparam int IDX_AND   = 0;
  localparam int IDX_OR    = 1;
  localparam int IDX_NOT   = 2;
  localparam int IDX_NAND  = 3;
  localparam int IDX_NAND2 = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/gate_checker_if.sv
// ============================================================================
//  Module      : gate_checker_if
//  Description : Stimulus, gate-output and result bundle between a gate
//                block driver (master) and the gate_checker (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gate_checker_if;

  logic       iStart;
  logic       iValid;
  logic       iA;
  logic       iB;
  logic       iAND;
  logic       iOR;
  logic       iNOT;
  logic       iNAND;
  logic       iNAND2;

  logic       oBusy;
  logic       oDone;
  logic       oPass;
  logic [7:0] oErrCnt;
  logic [7:0] oSampleCnt;
  logic [4:0] oFirstErrVec;
  logic [1:0] oFirstErrAB;
  logic [3:0] oCovered;

  modport master (
    output iStart, iValid, iA, iB, iAND, iOR, iNOT, iNAND, iNAND2,
    input  oBusy, oDone, oPass, oErrCnt, oSampleCnt, oFirstErrVec,
           oFirstErrAB, oCovered
  );

  modport slave (
    input  iStart, iValid, iA, iB, iAND, iOR, iNOT, iNAND, iNAND2,
    output oBusy, oDone, oPass, oErrCnt, oSampleCnt, oFirstErrVec,
           oFirstErrAB, oCovered
  );

endinterface

`default_nettype wire

// File: rtl/gate_checker_ref.sv
// ============================================================================
//  Module      : gate_ref
//  Description : Combinational golden model of the gate block: expected
//                AND, OR, NOT(a), NAND and second NAND for one {a,b} pair.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_ref (
  input  logic a,
  input  logic b,
  output logic y_and,
  output logic y_or,
  output logic y_not,
  output logic y_nand,
  output logic y_nand2
);

  assign y_and   = a & b;
  assign y_or    = a | b;
  assign y_not   = ~a;
  assign y_nand  = ~(a & b);
  assign y_nand2 = ~(a & b);

endmodule

`default_nettype wire

// File: rtl/gate_checker.sv
// ============================================================================
//  Module      : gate_checker
//  Description : Two-stage checker for a small gate block. Samples are
//                captured in RUN, compared one clock later against gate_ref
//                and accumulated into error / sample / coverage results that
//                are held in DONE until the next start.
//  Config      : GATE_CHK_NAND2_EN - when defined, the second NAND output is
//                checked and drives mismatch bit 4; otherwise it is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gate_checker
  import gate_chk_pkg::*;
#(
  parameter int NUM_SAMPLES = 4
) (
  input  logic          iClk,
  input  logic          iRst,
  gate_checker_if.slave bus
);

`ifdef GATE_CHK_NAND2_EN
  localparam logic [VEC_W-1:0] CHECK_MASK = 5'b11111;
`else
  localparam logic [VEC_W-1:0] CHECK_MASK = 5'b01111;
`endif

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_SAMPLES - 1);

  state_t             state;
  state_t             state_nxt;

  // Stage-1 capture registers
  logic               s1_valid;
  logic               s1_a;
  logic               s1_b;
  logic [VEC_W-1:0]   s1_gate;

  // Results
  logic [CNT_W-1:0]   cap_cnt;
  logic [CNT_W-1:0]   err_cnt;
  logic [CNT_W-1:0]   smp_cnt;
  logic [3:0]         covered;
  logic [VEC_W-1:0]   first_vec;
  logic [1:0]         first_ab;
  logic               first_seen;
  logic               pass;

  logic [VEC_W-1:0]   exp_vec;
  logic [VEC_W-1:0]   mis_vec;
  logic               unknown;
  logic [CNT_W-1:0]   err_acc;
  logic [3:0]         cov_acc;
  logic               capture;
  logic               start_run;

  gate_ref u_ref (
    .a       (s1_a),
    .b       (s1_b),
    .y_and   (exp_vec[IDX_AND]),
    .y_or    (exp_vec[IDX_OR]),
    .y_not   (exp_vec[IDX_NOT]),
    .y_nand  (exp_vec[IDX_NAND]),
    .y_nand2 (exp_vec[IDX_NAND2])
  );

  // Samples are only taken in RUN; a start is honoured only from IDLE/DONE
  assign capture   = (state == ST_RUN) && bus.iValid;
  assign start_run = ((state == ST_IDLE) || (state == ST_DONE)) && bus.iStart;

  // Per-bit mismatch; any X/Z on a checked stage-1 bit flags every enabled bit
  always_comb begin
    unknown = ((^{s1_a, s1_b, s1_gate & CHECK_MASK}) === 1'bx);
    mis_vec = '0;
    for (int i = 0; i < VEC_W; i++) begin
      mis_vec[i] = CHECK_MASK[i] && ((s1_gate[i] !== exp_vec[i]) || unknown);
    end
  end

  // Accumulated error count (saturating) and coverage after the stage-2 sample
  always_comb begin
    err_acc = err_cnt;
    cov_acc = covered;
    if (s1_valid) begin
      if ((mis_vec != '0) && (err_cnt != '1)) begin
        err_acc = err_cnt + CNT_W'(1);
      end
      cov_acc[{s1_a, s1_b}] = 1'b1;
    end
  end

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (bus.iStart) state_nxt = ST_RUN;
      ST_RUN:   if (capture && (cap_cnt == LAST_IDX)) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  if (bus.iStart) state_nxt = ST_RUN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage-1 capture, stage-2 accumulation and result latching
  always_ff @(posedge iClk) begin
    if (iRst) begin
      s1_valid   <= 1'b0;
      s1_a       <= 1'b0;
      s1_b       <= 1'b0;
      s1_gate    <= '0;
      cap_cnt    <= '0;
      err_cnt    <= '0;
      smp_cnt    <= '0;
      covered    <= '0;
      first_vec  <= '0;
      first_ab   <= '0;
      first_seen <= 1'b0;
      pass       <= 1'b0;
    end else begin
      s1_valid <= capture;
      if (capture) begin
        s1_a               <= bus.iA;
        s1_b               <= bus.iB;
        s1_gate[IDX_AND]   <= bus.iAND;
        s1_gate[IDX_OR]    <= bus.iOR;
        s1_gate[IDX_NOT]   <= bus.iNOT;
        s1_gate[IDX_NAND]  <= bus.iNAND;
        s1_gate[IDX_NAND2] <= bus.iNAND2;
      end

      if (start_run) begin
        cap_cnt    <= '0;
        err_cnt    <= '0;
        smp_cnt    <= '0;
        covered    <= '0;
        first_vec  <= '0;
        first_ab   <= '0;
        first_seen <= 1'b0;
        pass       <= 1'b0;
      end else begin
        if (capture) begin
          cap_cnt <= cap_cnt + CNT_W'(1);
        end
        if (s1_valid) begin
          smp_cnt <= smp_cnt + CNT_W'(1);
          err_cnt <= err_acc;
          covered <= cov_acc;
          if ((mis_vec != '0) && !first_seen) begin
            first_seen <= 1'b1;
            first_vec  <= mis_vec;
            first_ab   <= {s1_a, s1_b};
          end
        end
        // The DRAIN edge folds in the last sample, so judge on the accumulated view
        if (state == ST_DRAIN) begin
          pass <= (err_acc == '0) && (cov_acc == 4'hF);
        end
      end
    end
  end

  assign bus.oBusy        = (state == ST_RUN) || (state == ST_DRAIN);
  assign bus.oDone        = (state == ST_DONE);
  assign bus.oPass        = pass;
  assign bus.oErrCnt      = err_cnt;
  assign bus.oSampleCnt   = smp_cnt;
  assign bus.oFirstErrVec = first_vec;
  assign bus.oFirstErrAB  = first_ab;
  assign bus.oCovered     = covered;

endmodule

`default_nettype wire

// File: tb/tb_gate_checker.sv
// ============================================================================
//  Module      : tb_gate_checker
//  Description : Self-checking bench for gate_checker. A small model derives
//                the expected results of each run when its stimulus is built;
//                they are queued and compared when the checker reports done.
//                Two instances: NUM_SAMPLES=4 and NUM_SAMPLES=255.
//  Config      : GATE_CHK_NAND2_EN - selects expectations for the NAND2 check.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gate_checker;

`ifdef GATE_CHK_NAND2_EN
  localparam logic [4:0] NAND2_MASK = 5'b11111;
`else
  localparam logic [4:0] NAND2_MASK = 5'b01111;
`endif

  typedef struct packed {
    logic       a;
    logic       b;
    logic [4:0] g;  // [0]AND [1]OR [2]NOT [3]NAND [4]NAND2
  } smp_t;

  typedef struct packed {
    logic [7:0] err;
    logic [7:0] smp;
    logic [3:0] cov;
    logic [4:0] vec;
    logic [1:0] ab;
    logic       pass;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;
  res_t exp_q[$];
  smp_t stim[255];

  gate_checker_if bus4 ();
  gate_checker_if bus255 ();

  gate_checker #(.NUM_SAMPLES(4)) u_dut4 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus4)
  );

  gate_checker #(.NUM_SAMPLES(255)) u_dut255 (
    .iClk (clk),
    .iRst (rst),
    .bus  (bus255)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [4:0] good_gates(input logic a, input logic b);
    return {~(a & b), ~(a & b), ~a, a | b, a & b};
  endfunction

  function automatic smp_t mk(input logic a, input logic b, input logic [4:0] fault);
    smp_t s;
    s.a = a;
    s.b = b;
    s.g = good_gates(a, b) ^ fault;
    return s;
  endfunction

  // Model of one run over stim[0..n-1]; result is queued for later comparison
  function automatic void push_exp(input int n);
    res_t       e;
    logic [4:0] v;
    bit         seen;
    e    = '0;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      v = (stim[i].g ^ good_gates(stim[i].a, stim[i].b)) & NAND2_MASK;
      e.smp = e.smp + 8'd1;
      e.cov[{stim[i].a, stim[i].b}] = 1'b1;
      if (v != 5'd0) begin
        if (e.err != 8'hFF) e.err = e.err + 8'd1;
        if (!seen) begin
          seen = 1;
          e.vec = v;
          e.ab  = {stim[i].a, stim[i].b};
        end
      end
    end
    e.pass = (e.err == 8'd0) && (e.cov == 4'hF);
    exp_q.push_back(e);
  endfunction

  task automatic compare_out(input string tag, input logic done, input logic pass,
                             input logic [7:0] err, input logic [7:0] smp,
                             input logic [3:0] cov, input logic [4:0] vec,
                             input logic [1:0] ab);
    res_t e;
    check({tag, "_sb_entry"}, exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, "_done"}, done, 1);
    check({tag, "_err"},  err,  e.err);
    check({tag, "_smp"},  smp,  e.smp);
    check({tag, "_cov"},  cov,  e.cov);
    check({tag, "_vec"},  vec,  e.vec);
    check({tag, "_ab"},   ab,   e.ab);
    check({tag, "_pass"}, pass, e.pass);
  endtask

  task automatic check_zero4(input string tag);
    check({tag, "_busy"}, bus4.oBusy, 0);
    check({tag, "_done"}, bus4.oDone, 0);
    check({tag, "_pass"}, bus4.oPass, 0);
    check({tag, "_err"},  bus4.oErrCnt, 0);
    check({tag, "_smp"},  bus4.oSampleCnt, 0);
    check({tag, "_vec"},  bus4.oFirstErrVec, 0);
    check({tag, "_ab"},   bus4.oFirstErrAB, 0);
    check({tag, "_cov"},  bus4.oCovered, 0);
  endtask

  task automatic drive4(input smp_t s);
    bus4.iA     = s.a;
    bus4.iB     = s.b;
    bus4.iAND   = s.g[0];
    bus4.iOR    = s.g[1];
    bus4.iNOT   = s.g[2];
    bus4.iNAND  = s.g[3];
    bus4.iNAND2 = s.g[4];
  endtask

  task automatic drive255(input smp_t s);
    bus255.iA     = s.a;
    bus255.iB     = s.b;
    bus255.iAND   = s.g[0];
    bus255.iOR    = s.g[1];
    bus255.iNOT   = s.g[2];
    bus255.iNAND  = s.g[3];
    bus255.iNAND2 = s.g[4];
  endtask

  // One 4-sample run on the small instance using stim[0..3]
  task automatic run4(input string tag, input bit gap, input bit start_mid);
    int k;
    push_exp(4);
    bus4.iStart = 1'b1;
    tick();
    bus4.iStart = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (gap) tick();
      drive4(stim[i]);
      bus4.iValid = 1'b1;
      if (start_mid && i == 1) bus4.iStart = 1'b1;
      tick();
      bus4.iValid = 1'b0;
      bus4.iStart = 1'b0;
    end
    check({tag, "_busy_drain"}, bus4.oBusy, 1);
    check({tag, "_done_early"}, bus4.oDone, 0);
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus4.oDone && k < 6);
    check({tag, "_done_lat"}, k, 1);
    compare_out(tag, bus4.oDone, bus4.oPass, bus4.oErrCnt, bus4.oSampleCnt,
                bus4.oCovered, bus4.oFirstErrVec, bus4.oFirstErrAB);
  endtask

  initial begin
    rst = 1'b1;
    bus4.iStart = 1'b0;   bus4.iValid = 1'b0;
    bus255.iStart = 1'b0; bus255.iValid = 1'b0;
    drive4(mk(1'b0, 1'b0, 5'd0));
    drive255(mk(1'b0, 1'b0, 5'd0));
    repeat (3) tick();
    check_zero4("reset");
    check("reset255_busy", bus255.oBusy, 0);
    check("reset255_smp",  bus255.oSampleCnt, 0);
    rst = 1'b0;
    tick();

    // Good gate, full coverage
    stim[0] = mk(0, 0, 5'd0); stim[1] = mk(0, 1, 5'd0);
    stim[2] = mk(1, 0, 5'd0); stim[3] = mk(1, 1, 5'd0);
    run4("good", 0, 0);
    repeat (3) tick();
    check("hold_done", bus4.oDone, 1);
    check("hold_smp",  bus4.oSampleCnt, 4);

    // OR stuck low on 10, with idle cycles between samples
    stim[2] = mk(1, 0, 5'b00010);
    run4("or_fault", 1, 0);

    // Incomplete coverage; a start pulse mid-run must be ignored
    stim[0] = mk(0, 0, 5'd0); stim[1] = mk(0, 1, 5'd0);
    stim[2] = mk(0, 1, 5'd0); stim[3] = mk(1, 1, 5'd0);
    run4("partial", 0, 1);

    // NAND2 stuck high on 11 -- outcome depends on the build
    stim[0] = mk(0, 0, 5'd0); stim[1] = mk(0, 1, 5'd0);
    stim[2] = mk(1, 0, 5'd0); stim[3] = mk(1, 1, 5'b10000);
    run4("nand2", 0, 0);

    // Reset mid-run, together with start and valid
    bus4.iStart = 1'b1;
    tick();
    bus4.iStart = 1'b0;
    drive4(mk(1, 0, 5'b00010)); bus4.iValid = 1'b1; tick();
    drive4(mk(0, 1, 5'd0));     tick();
    check("mid_smp", bus4.oSampleCnt, 1);
    check("mid_vec", bus4.oFirstErrVec, 5'b00010);
    rst = 1'b1; bus4.iStart = 1'b1;
    drive4(mk(1, 1, 5'b00001));
    tick();
    rst = 1'b0; bus4.iStart = 1'b0; bus4.iValid = 1'b0;
    check_zero4("midrst");
    tick();
    check("midrst_idle", bus4.oBusy, 0);

    // Normal run after reset
    stim[0] = mk(1, 1, 5'd0); stim[1] = mk(1, 0, 5'd0);
    stim[2] = mk(0, 1, 5'b00100); stim[3] = mk(0, 0, 5'b01000);
    run4("after_rst", 0, 0);

    // 255 samples, all wrong, extra valid in DRAIN and DONE
    for (int i = 0; i < 255; i++) stim[i] = mk(i[1], i[0], 5'b00001);
    push_exp(255);
    bus255.iStart = 1'b1;
    tick();
    bus255.iStart = 1'b0;
    for (int i = 0; i < 255; i++) begin
      drive255(stim[i]);
      bus255.iValid = 1'b1;
      tick();
    end
    check("big_busy_drain", bus255.oBusy, 1);
    tick();
    check("big_done_lat", bus255.oDone, 1);
    tick();
    tick();
    bus255.iValid = 1'b0;
    compare_out("big", bus255.oDone, bus255.oPass, bus255.oErrCnt, bus255.oSampleCnt,
                bus255.oCovered, bus255.oFirstErrVec, bus255.oFirstErrAB);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 SHALL have parameter NUM_SAMPLES, default 4, number of valid samples checked per run (1..255).
REQ-002 SHALL have port iClk  input  1  rising-edge clock; reset is synchronous and active-high.
REQ-003 SHALL have port iRst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port iStart  input  1  one-cycle pulse that begins a run.
REQ-005 SHALL have port iValid  input  1  high when the current iA/iB/gate outputs form a sample.
REQ-006 SHALL have ports iA, iB  input  1 each  stimulus driven to the gate block.
REQ-007 SHALL have ports iAND, iOR, iNOT, iNAND, iNAND2  input  1 each  gate-block outputs under check.
REQ-008 SHALL have port oBusy  output  1  high in RUN or DRAIN.
REQ-009 SHALL have port oDone  output  1  high in DONE.
REQ-010 SHALL have port oPass  output  1  valid in DONE: no errors and all four input combinations covered.
REQ-011 SHALL have port oErrCnt  output  8  count of mismatching samples, saturating at 255.
REQ-012 SHALL have port oSampleCnt  output  8  count of accumulated samples.
REQ-013 SHALL have port oFirstErrVec  output  5  mismatch bits of first failing sample: [0]AND [1]OR [2]NOT [3]NAND [4]NAND2.
REQ-014 SHALL have port oFirstErrAB  output  2  {iA,iB} of first failing sample.
REQ-015 SHALL have port oCovered  output  4  bit {iA,iB} set once that combination is accumulated.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE->RUN and DONE->RUN on iStart; entry into RUN clears all counters, oCovered, oFirstErrVec, oFirstErrAB.
REQ-018 SHALL ignore iStart in RUN and DRAIN.
REQ-019 Stage 1: in RUN, the edge with iValid=1 registers iA, iB and all gate inputs plus a valid flag.
REQ-020 Stage 2: the next edge compares stage-1 data with expected AND, OR, NOT(iA), NAND, NAND and accumulates.
REQ-021 RUN->DRAIN on the edge capturing the NUM_SAMPLES-th sample; iValid ignored in DRAIN, DONE, IDLE.
REQ-022 DRAIN->DONE on the next edge, which accumulates the final sample; last iValid to oDone = 2 clocks.
REQ-023 Accumulation: oSampleCnt +1; set oCovered[{A,B}]; if mismatch vector nonzero, oErrCnt +1 unless at 255.
REQ-024 oFirstErrVec/oFirstErrAB SHALL latch only on the first mismatch of a run and then hold.
REQ-025 X or Z on any checked input SHALL count as a mismatch in simulation.
REQ-026 oPass = (oErrCnt==0) && (oCovered==4'hF), registered, meaningful only while oDone=1.
REQ-027 DONE SHALL hold all results until iStart or iRst.

Reset
REQ-028 iRst SHALL, at any state including mid-run, force IDLE and zero every output and stage-1 register on the next edge.
REQ-029 iRst SHALL take priority over iStart and iValid in the same cycle.

Configuration
REQ-030 With GATE_CHK_NAND2_EN defined, iNAND2 SHALL be checked against NAND and drive mismatch bit 4.
REQ-031 Without GATE_CHK_NAND2_EN, iNAND2 SHALL be ignored and bit 4 of the mismatch vector and oFirstErrVec SHALL be 0.

Structure
REQ-032 Package gate_chk_pkg SHALL hold the FSM state enum, the mismatch-bit index constants, and the counter width constant (8).
REQ-033 Combinational expected-value model SHALL be sub-module gate_ref (iA, iB -> five expected outputs).

Verification
REQ-034 Correct gate, iStart, samples 00,01,10,11 each with iValid -> oDone 2 clocks after last, oPass=1, oErrCnt=0, oCovered=F.
REQ-035 oOR forced 0 on sample 10 -> oErrCnt=1, oFirstErrVec=00010, oFirstErrAB=10, oPass=0.
REQ-036 Only 00,01,01,11 applied -> oErrCnt=0, oCovered=1011, oPass=0.
REQ-037 iNAND2 stuck 1 on 11, both macro builds -> macro on: oErrCnt=1, vec=10000; macro off: oErrCnt=0, oPass=1.
REQ-038 iRst after two samples -> next edge IDLE, all outputs 0; new iStart runs normally.
REQ-039 NUM_SAMPLES=255, every sample wrong, plus extra iValid in DRAIN -> oErrCnt=255, oSampleCnt=255, extra ignored.
